// File: rtl/pipelined_adder_if.sv
// -----------------------------------------------------------------------------
// pipelined_adder_if
// Bundles the operand/result handshake of pipelined_adder.
//
// Handshake semantics (both channels): a beat transfers on a rising clock edge
// when valid && ready are both high. A source holds valid and its payload
// stable until the transfer; ready may change freely and never depends on
// valid.
//
// Signals
//   in_valid / in_ready : operand channel (A, B, ci, sub, SEL)
//   out_valid / out_ready : result channel (out, and ovf when enabled)
//   A, B   : N-bit unsigned operands
//   ci     : carry-in, ignored when sub=1
//   sub    : 1 selects A - B
//   SEL    : 0 forces a zero result for that beat
//   out    : N+1 bit result {carry_out, sum}
//   ovf    : signed overflow flag (only with PIPELINED_ADDER_OVF_EN defined)
//
// Modports: slave = adder side, master = producer/consumer side.
// Optional feature macro: PIPELINED_ADDER_OVF_EN
// -----------------------------------------------------------------------------
interface pipelined_adder_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         ci;
  logic         sub;
  logic         SEL;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   out;
`ifdef PIPELINED_ADDER_OVF_EN
  logic         ovf;

  modport slave (
    input  in_valid, A, B, ci, sub, SEL, out_ready,
    output in_ready, out_valid, out, ovf
  );
  modport master (
    output in_valid, A, B, ci, sub, SEL, out_ready,
    input  in_ready, out_valid, out, ovf
  );
`else
  modport slave (
    input  in_valid, A, B, ci, sub, SEL, out_ready,
    output in_ready, out_valid, out
  );
  modport master (
    output in_valid, A, B, ci, sub, SEL, out_ready,
    input  in_ready, out_valid, out
  );
`endif
endinterface

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
// N-bit add/subtract split into STAGES carry-save segments of W = N/STAGES
// bits. Stage k adds chunk k of A and the effective B plus the carry registered
// by stage k-1; operands not yet consumed and partial sums already formed ride
// along with the beat. The last stage register drives the result, so a beat
// accepted in cycle t presents out_valid in cycle t+STAGES.
//
// Ports
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset, clears all stage valid bits
//   bus  : pipelined_adder_if.slave (operand and result handshakes)
//
// Flow control: the whole pipeline advances together when the output register
// is empty or being drained (advance = !out_valid || out_ready). in_ready is
// exactly advance. When advance is low every stage register holds.
//
// Optional feature macro: PIPELINED_ADDER_OVF_EN adds bus.ovf, the N-bit
// signed overflow of A op B, gated by SEL and held with the result.
// -----------------------------------------------------------------------------
module pipelined_adder #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  pipelined_adder_if.slave     bus
);
  localparam int W = N / STAGES;

  logic advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Sources feeding this stage (inputs for stage 0, previous stage otherwise)
    logic [N-1:0] a_s, be_s, sum_s;
    logic         c_s, sel_s, v_s;

    // Stage registers
    logic [N-1:0] a_q, be_q, sum_q;
    logic         c_q, sel_q, v_q;

    logic [N-1:0] sum_d;
    logic [W:0]   chunk;

    if (k == 0) begin : g_first
      // Subtraction is A + ~B + 1; ci only matters for addition.
      assign a_s   = bus.A;
      assign be_s  = bus.sub ? ~bus.B : bus.B;
      assign c_s   = bus.sub ? 1'b1 : bus.ci;
      assign sel_s = bus.SEL;
      assign v_s   = bus.in_valid;
      assign sum_s = '0;
    end else begin : g_next
      assign a_s   = g_stage[k-1].a_q;
      assign be_s  = g_stage[k-1].be_q;
      assign c_s   = g_stage[k-1].c_q;
      assign sel_s = g_stage[k-1].sel_q;
      assign v_s   = g_stage[k-1].v_q;
      assign sum_s = g_stage[k-1].sum_q;
    end

    assign chunk = {1'b0, a_s[k*W +: W]} + {1'b0, be_s[k*W +: W]} + {{W{1'b0}}, c_s};

    always_comb begin
      sum_d            = sum_s;
      sum_d[k*W +: W]  = chunk[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q   <= 1'b0;
        sel_q <= 1'b0;
        c_q   <= 1'b0;
        a_q   <= '0;
        be_q  <= '0;
        sum_q <= '0;
      end else if (advance) begin
        v_q   <= v_s;
        // Bubbles carry SEL=0 so the result register reads zero when empty.
        sel_q <= sel_s & v_s;
        c_q   <= chunk[W];
        a_q   <= a_s;
        be_q  <= be_s;
        sum_q <= sum_d;
      end
    end
  end

  assign advance       = !g_stage[STAGES-1].v_q || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = g_stage[STAGES-1].v_q;
  assign bus.out       = g_stage[STAGES-1].sel_q
                         ? {g_stage[STAGES-1].c_q, g_stage[STAGES-1].sum_q}
                         : '0;

`ifdef PIPELINED_ADDER_OVF_EN
  // Overflow: operands share a sign and the sum's sign differs from it.
  assign bus.ovf = g_stage[STAGES-1].sel_q
                   && (g_stage[STAGES-1].a_q[N-1] == g_stage[STAGES-1].be_q[N-1])
                   && (g_stage[STAGES-1].sum_q[N-1] != g_stage[STAGES-1].a_q[N-1]);
`endif

  // Operand copies leaving the last stage are only partly needed.
  logic unused_last;
  assign unused_last = ^{g_stage[STAGES-1].a_q, g_stage[STAGES-1].be_q};

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;
  localparam int N      = 8;
  localparam int STAGES = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_adder_if #(.N(N)) bus();

  pipelined_adder #(.N(N), .STAGES(STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  logic [N+1:0] exp_q[$];   // {ovf, out}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic ci, input logic sub, input logic sel);
    logic [N-1:0] be;
    logic         cin;
    logic [N:0]   full;
    logic         ov;
    be   = sub ? ~b : b;
    cin  = sub ? 1'b1 : ci;
    full = {1'b0, a} + {1'b0, be} + {{N{1'b0}}, cin};
    ov   = (a[N-1] == be[N-1]) && (full[N-1] != a[N-1]);
    return sel ? {ov, full} : '0;
  endfunction

  // Monitor: sampled on the falling edge, mirrors what transfers at the next rising edge.
  always @(negedge clk) begin
    logic [N+1:0] e;
    check("in_ready", {31'd0, bus.in_ready},
          {31'd0, rst ? 1'b1 : (!bus.out_valid || bus.out_ready)});
    if (!rst && bus.in_valid && bus.in_ready)
      exp_q.push_back(model(bus.A, bus.B, bus.ci, bus.sub, bus.SEL));
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out", {23'd0, bus.out}, {23'd0, e[N:0]});
`ifdef PIPELINED_ADDER_OVF_EN
        check("ovf", {31'd0, bus.ovf}, {31'd0, e[N+1]});
`endif
        n_out++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one beat and returns 1 ns after the edge on which it transferred.
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic ci, input logic sub, input logic sel);
    bit ok = 0;
    bus.A = a; bus.B = b; bus.ci = ci; bus.sub = sub; bus.SEL = sel;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  // Single beat with latency and value checks against a known constant.
  task automatic directed(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic ci, input logic sub, input logic sel,
                          input logic [N:0] exp_out, input logic exp_ovf);
    send(a, b, ci, sub, sel);
    check({tag, "_early"}, {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_out"}, {23'd0, bus.out}, {23'd0, exp_out});
`ifdef PIPELINED_ADDER_OVF_EN
    check({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, exp_ovf});
`else
    if (exp_ovf) begin end
`endif
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.ci = 1'b0; bus.sub = 1'b0; bus.SEL = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out", {23'd0, bus.out}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    rst = 1'b0;

    // Known vectors
    directed("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 1'b1, 9'h010, 1'b0);
    directed("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 9'h100, 1'b0);
    directed("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 1'b1, 9'h0FE, 1'b0);
    directed("sel0",      8'hAA, 8'h55, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0);
    directed("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 9'h080, 1'b1);

    // 10 back-to-back beats with a 3-cycle output stall in the middle
    base = n_out;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(N'($urandom_range(0, 255)), N'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
          check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
          @(posedge clk);
        end
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    check("burst_count", n_out - base, 32'd10);

    // Random bubbles and random backpressure
    base = n_out;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          send(N'($urandom_range(0, 255)), N'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drain();
    check("random_count", n_out - base, 32'd20);

    // Reset mid-cycle with two beats in flight
    send(8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
    send(8'h33, 8'h44, 1'b1, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_out", {23'd0, bus.out}, 32'd0);
    bus.out_ready = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    rst = 1'b0;
    directed("post_rst", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 9'h080, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
